imem_loader: RTL and testbench
==============================

# imem_loader

Host-side writer for the instruction memory's load port. It accepts a byte stream over a valid/ready handshake, assembles big-endian 32-bit words, and drives `imem`'s `a`/`wd`/`we` port to fill consecutive words from address 0. It holds the CPU stalled while loading. It sits between the board's host link (UART/JTAG byte source) and `imem`; the top level muxes `imem_a` onto `imem.a` while `cpu_hold` is high.

## Interface
Parameters:
- `DEPTH`, 32: number of imem words; maximum legal load length.
- `ADDR_W`, 6: width of the imem word address.

Ports:
- `clk`  in  1: system clock. All logic is on the rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `start`  in  1: one-cycle pulse that begins a load session.
- `byte_valid`  in  1: host byte present.
- `byte_data`  in  8: host byte.
- `byte_ready`  out  1: loader accepts a byte this cycle.
- `imem_a`  out  ADDR_W: imem word address.
- `imem_wd`  out  32: imem write data.
- `imem_we`  out  1: imem write enable, single-cycle.
- `cpu_hold`  out  1: CPU must stall/stay in reset. Also selects the loader onto the imem port.
- `done`  out  1: one-cycle pulse when the load completes.
- `err`  out  1: sticky error flag for a bad header.

## Operation
- A byte transfers when `byte_valid && byte_ready` at a rising edge. There is no other consumption.
- Stream format: header byte N (word count), then 4·N data bytes, MSB first within each word. Legal range: 1 ≤ N ≤ DEPTH.
- States:
  - IDLE: ignores bytes. `start` → HDR.
  - HDR: `byte_ready`=1. On accepting N: if N==0 or N>DEPTH → ERR; else latch N, clear word index and byte count → DATA.
  - DATA: `byte_ready`=1. Each accepted byte shifts into the word: word ← {word[23:0], byte_data}, and the byte count increments mod 4. The 4th byte → WRITE.
  - WRITE: single cycle. `byte_ready`=0, `imem_we`=1, `imem_a`=word index, `imem_wd`=assembled word. Index increments. If the new index == N → DONE, else → DATA.
  - DONE: single cycle. `done`=1, `cpu_hold`=0 → IDLE.
  - ERR: `err`=1, `cpu_hold`=1, `byte_ready`=0. Leaves only on `start` (→ HDR, `err` cleared) or `reset`.
- `cpu_hold`=1 in HDR, DATA, WRITE and ERR; 0 in IDLE and DONE.
- `start` is ignored in HDR, DATA, WRITE and DONE.
- Word index is ADDR_W bits and never wraps, because N ≤ DEPTH ≤ 2^ADDR_W.
- Bytes presented in IDLE or ERR are not accepted, since `byte_ready`=0.

## Timing
- All outputs are registered or decoded from the state register; no combinational path from `byte_valid` to any output.
- Reset values: state IDLE; `byte_ready`, `imem_we`, `cpu_hold`, `done`, `err` all 0; `imem_a` 0; `imem_wd` 0.
- The imem write occurs on the edge ending the WRITE cycle: the cycle after the 4th byte of a word is accepted.
- Throughput with `byte_valid` held high: 5 cycles per word (4 accepts + WRITE).
- A full load of N words from the `start` pulse takes 1 (HDR accept) + 5N cycles before DONE, assuming no host stalls.
- `done` asserts in the cycle after the last WRITE.
- Host stalls (`byte_valid`=0) hold state, partial word and count unchanged. No timeout.
- A `reset` mid-load aborts immediately to IDLE. Words already written stay in imem; there is no rollback.
- `start` and `reset` in the same cycle: `reset` wins.

## Structure
- Shared package `mips_mem_pkg`: the state enum (IDLE, HDR, DATA, WRITE, DONE, ERR), `IMEM_DEPTH`=32, `IMEM_ADDR_W`=6.
- Natural sub-module `byte_word_packer`: 2-bit byte counter plus 32-bit shift register, with an `accept` input and a `word_full` output.
- The top FSM owns the header check, the word index and the imem drive.

## Test plan
- Load N=2, bytes 02 DE AD BE EF 01 23 45 67 with valid held high → WRITE cycles at addr 0 wd 0xDEADBEEF, then addr 1 wd 0x01234567. `done` pulses 11 cycles after `start`. `cpu_hold` is low again in the `done` cycle.
- Same stream with `byte_valid` low for 3 cycles between every byte → identical writes and data. `byte_ready` stays 1 throughout HDR/DATA; only the timing stretches.
- Header 0x00 → ERR. `err`=1, `cpu_hold`=1, no `imem_we`. A following `start` plus a good stream loads normally and `err` clears.
- Header 0x21 (33 > DEPTH) → ERR, no writes. Header 0x20 with 128 bytes → 32 writes at addresses 0..31, then `done`.
- `start` pulsed during DATA → ignored; the load completes unchanged.
- `reset` after 1.5 words → IDLE with all outputs 0. The word at addr 0 remains written, and no write occurs to addr 1.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// Shared definitions for the instruction-memory side of the MIPS board:
// imem geometry and the loader state encoding.
package mips_mem_pkg;

  localparam int IMEM_DEPTH  = 32;
  localparam int IMEM_ADDR_W = 6;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    DATA,
    WRITE,
    DONE,
    ERR
  } ld_state_e;

endpackage

// File: rtl/imem_loader_byte_word_packer.sv
// Collects four accepted bytes MSB-first into a 32-bit word and flags the
// byte that completes it.
module byte_word_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        accept,
  input  logic [7:0]  byte_data,
  output logic [31:0] word,
  output logic        word_full
);

  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] word_q, word_d;

  always_comb begin
    cnt_d  = cnt_q;
    word_d = word_q;
    if (clear) begin
      cnt_d = 2'd0;
    end else if (accept) begin
      word_d = {word_q[23:0], byte_data};
      cnt_d  = cnt_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= 2'd0;
      word_q <= 32'd0;
    end else begin
      cnt_q  <= cnt_d;
      word_q <= word_d;
    end
  end

  // Asserted alongside the 4th accept so the FSM enters WRITE with the word complete.
  assign word_full = accept && (cnt_q == 2'd3);
  assign word      = word_q;

endmodule

// File: rtl/imem_loader.sv
// Host byte-stream loader for imem: header N, then N big-endian words written
// to addresses 0..N-1 while the CPU is held.
module imem_loader
  import mips_mem_pkg::*;
#(
  parameter int DEPTH  = IMEM_DEPTH,
  parameter int ADDR_W = IMEM_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic [ADDR_W-1:0] imem_a,
  output logic [31:0]       imem_wd,
  output logic              imem_we,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

  localparam int NW = ADDR_W + 1;

  ld_state_e         state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [NW-1:0]     n_q, n_d;
  logic [NW-1:0]     idx_inc;
  logic              accept, hdr_bad, pk_clear, pk_accept, word_full;
  logic [31:0]       pk_word;

  assign byte_ready = (state_q == HDR) || (state_q == DATA);
  assign accept     = byte_valid && byte_ready;
  assign hdr_bad    = (byte_data == 8'd0) || (32'(byte_data) > 32'(DEPTH));
  // One bit wider than the index so reaching N == 2^ADDR_W compares correctly.
  assign idx_inc    = {1'b0, idx_q} + NW'(1);
  assign pk_clear   = (state_q == HDR) && accept && !hdr_bad;
  assign pk_accept  = (state_q == DATA) && accept;

  byte_word_packer u_pack (
    .clk       (clk),
    .reset     (reset),
    .clear     (pk_clear),
    .accept    (pk_accept),
    .byte_data (byte_data),
    .word      (pk_word),
    .word_full (word_full)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    n_d     = n_q;
    case (state_q)
      IDLE:  if (start) state_d = HDR;
      HDR: begin
        if (accept) begin
          if (hdr_bad) begin
            state_d = ERR;
          end else begin
            n_d     = NW'(byte_data);
            idx_d   = '0;
            state_d = DATA;
          end
        end
      end
      DATA:  if (word_full) state_d = WRITE;
      WRITE: begin
        idx_d   = idx_inc[ADDR_W-1:0];
        state_d = (idx_inc == n_q) ? DONE : DATA;
      end
      DONE:  state_d = IDLE;
      ERR:   if (start) state_d = HDR;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      n_q     <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      n_q     <= n_d;
    end
  end

  assign imem_we  = (state_q == WRITE);
  assign imem_a   = idx_q;
  assign imem_wd  = pk_word;
  assign cpu_hold = (state_q == HDR) || (state_q == DATA) ||
                    (state_q == WRITE) || (state_q == ERR);
  assign done     = (state_q == DONE);
  assign err      = (state_q == ERR);

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table of load sessions plus corner
// sequences; expected imem writes flow through a scoreboard queue.
module tb_imem_loader;
  import mips_mem_pkg::*;

  localparam int AW = IMEM_ADDR_W;

  logic          clk = 1'b0;
  logic          reset, start, byte_valid;
  logic [7:0]    byte_data;
  logic          byte_ready, imem_we, cpu_hold, done, err;
  logic [AW-1:0] imem_a;
  logic [31:0]   imem_wd;

  imem_loader #(.DEPTH(IMEM_DEPTH), .ADDR_W(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .imem_a     (imem_a),
    .imem_wd    (imem_wd),
    .imem_we    (imem_we),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] a;
    logic [31:0]   wd;
  } wr_t;

  typedef struct {
    logic [7:0]  hdr;
    int          gap;
    bit          bad;
    bit          plan;
    logic [31:0] seed;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   wr_cnt = 0;
  int   t0 = 0;
  wr_t  exp_q[$];
  vec_t tbl[7];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Scoreboard consumer: every imem write must match the head of the queue.
  always @(negedge clk) begin
    wr_t e;
    if (imem_we) begin
      wr_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexp_write: addr %0d wd %h but no write expected", imem_a, imem_wd);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", 32'(imem_a), 32'(e.a));
        chk("wr_data", imem_wd, e.wd);
      end
    end
    if (done) chk("hold_in_done", 32'(cpu_hold), 32'd0);
  end

  function automatic logic [31:0] gen(int i, logic [31:0] seed, bit plan);
    if (plan) return (i == 0) ? 32'hDEADBEEF : 32'h01234567;
    return seed ^ (32'(i) * 32'h9E3779B1);
  endfunction

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t0 = cyc;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    logic acc;
    acc = 1'b0;
    for (int g = 0; g < gap; g++) begin
      byte_valid = 1'b0;
      if (g > 0) chk("rdy_gap", 32'(byte_ready), 32'd1);
      @(negedge clk);
    end
    byte_valid = 1'b1;
    byte_data  = b;
    for (int t = 0; t < 60; t++) begin
      acc = byte_ready;
      @(negedge clk);
      if (acc) break;
    end
    if (!acc) chk("byte_accept_timeout", 32'(acc), 32'd1);
    byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [AW-1:0] a, input logic [31:0] w, input int gap);
    exp_q.push_back('{a: a, wd: w});
    for (int k = 0; k < 4; k++) send_byte(w[31-8*k -: 8], gap);
  endtask

  task automatic wait_done(output int dcyc);
    for (int t = 0; t < 40; t++) begin
      if (done) break;
      @(negedge clk);
    end
    if (!done) chk("done_timeout", 32'(done), 32'd1);
    dcyc = cyc;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rdy"},  32'(byte_ready), 32'd0);
    chk({tag, "_we"},   32'(imem_we),    32'd0);
    chk({tag, "_hold"}, 32'(cpu_hold),   32'd0);
    chk({tag, "_done"}, 32'(done),       32'd0);
    chk({tag, "_err"},  32'(err),        32'd0);
    chk({tag, "_a"},    32'(imem_a),     32'd0);
    chk({tag, "_wd"},   imem_wd,         32'd0);
  endtask

  initial begin
    int dc, w0;
    reset = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;

    tbl[0] = '{hdr: 8'd2,  gap: 0, bad: 1'b0, plan: 1'b1, seed: 32'h0};
    tbl[1] = '{hdr: 8'd2,  gap: 3, bad: 1'b0, plan: 1'b1, seed: 32'h0};
    tbl[2] = '{hdr: 8'd0,  gap: 0, bad: 1'b1, plan: 1'b0, seed: 32'h0};
    tbl[3] = '{hdr: 8'd1,  gap: 1, bad: 1'b0, plan: 1'b0, seed: 32'h5A5A1234};
    tbl[4] = '{hdr: 8'd33, gap: 0, bad: 1'b1, plan: 1'b0, seed: 32'h0};
    tbl[5] = '{hdr: 8'd32, gap: 0, bad: 1'b0, plan: 1'b0, seed: 32'hC0DE0000};
    tbl[6] = '{hdr: 8'd5,  gap: 2, bad: 1'b0, plan: 1'b0, seed: 32'h0F0F7777};

    repeat (3) @(negedge clk);
    chk_all_zero("rst");
    reset = 1'b0;
    @(negedge clk);

    for (int r = 0; r < 7; r++) begin
      pulse_start();
      chk("hdr_hold", 32'(cpu_hold), 32'd1);
      chk("hdr_rdy", 32'(byte_ready), 32'd1);
      chk("hdr_err_clr", 32'(err), 32'd0);
      send_byte(tbl[r].hdr, tbl[r].gap);
      if (tbl[r].bad) begin
        w0 = wr_cnt;
        byte_valid = 1'b1;
        byte_data  = 8'h55;
        repeat (3) begin
          chk("err_flag", 32'(err), 32'd1);
          chk("err_hold", 32'(cpu_hold), 32'd1);
          chk("err_rdy", 32'(byte_ready), 32'd0);
          @(negedge clk);
        end
        byte_valid = 1'b0;
        chk("err_nowr", 32'(wr_cnt), 32'(w0));
      end else begin
        for (int i = 0; i < int'(tbl[r].hdr); i++)
          send_word(AW'(i), gen(i, tbl[r].seed, tbl[r].plan), tbl[r].gap);
        wait_done(dc);
        if (tbl[r].gap == 0) chk("done_lat", 32'(dc - t0), 32'(1 + 5 * int'(tbl[r].hdr)));
        chk("drain", 32'(exp_q.size()), 32'd0);
        chk("done_err", 32'(err), 32'd0);
        @(negedge clk);
        chk("idle_hold", 32'(cpu_hold), 32'd0);
        chk("idle_done", 32'(done), 32'd0);
      end
    end

    // start during DATA must not disturb the session
    pulse_start();
    send_byte(8'd1, 0);
    exp_q.push_back('{a: AW'(0), wd: 32'hCAFEF00D});
    send_byte(8'hCA, 0);
    send_byte(8'hFE, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_ign_hold", 32'(cpu_hold), 32'd1);
    chk("start_ign_rdy", 32'(byte_ready), 32'd1);
    send_byte(8'hF0, 0);
    send_byte(8'h0D, 0);
    wait_done(dc);
    chk("start_ign_drain", 32'(exp_q.size()), 32'd0);
    @(negedge clk);

    // reset after 1.5 words: word 0 stays written, nothing further
    w0 = wr_cnt;
    pulse_start();
    send_byte(8'd2, 0);
    send_word(AW'(0), 32'h11223344, 0);
    send_byte(8'h55, 0);
    send_byte(8'h66, 0);
    chk("mid_w0_written", 32'(wr_cnt - w0), 32'd1);
    w0 = wr_cnt;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk_all_zero("midrst");
    byte_valid = 1'b1;
    byte_data  = 8'h77;
    repeat (8) @(negedge clk);
    chk("midrst_rdy", 32'(byte_ready), 32'd0);
    byte_valid = 1'b0;
    chk("midrst_nowr", 32'(wr_cnt), 32'(w0));
    chk("midrst_drain", 32'(exp_q.size()), 32'd0);

    // reset wins over a simultaneous start
    reset = 1'b1;
    start = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    chk("rst_start_hold", 32'(cpu_hold), 32'd0);
    @(negedge clk);
    chk("rst_start_idle", 32'(cpu_hold), 32'd0);
    chk("rst_start_rdy", 32'(byte_ready), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
